cache_profiler_reader: RTL
==========================

Name: cache_profiler_reader

Overview:
- Readout side for the cache profiler's six 32-bit counters.
- On a snapshot request it latches all counters in a single cycle, so the frame is a coherent snapshot.
- It then streams the snapshot as an 8-word framed packet over a valid/ready stream to the host-side transport.
- It also tracks a frame sequence number and counts requests dropped while busy.

Parameters:
- HEADER_MAGIC, 16'hCA5E, upper 16 bits of the frame header word.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset. One clock domain; reset is synchronous and active-high.
- enable  input  1  when low, new snapshot requests are ignored.
- snapshot_req  input  1  level signal; each rising edge requests one snapshot.
- icache_hit_counter  input  32  live counter.
- icache_miss_counter  input  32  live counter.
- icache_request_counter  input  32  live counter.
- dcache_hit_counter  input  32  live counter.
- dcache_miss_counter  input  32  live counter.
- dcache_request_counter  input  32  live counter.
- m_valid  output  1  stream word valid.
- m_data  output  32  stream word.
- m_last  output  1  high on the final word of a frame.
- m_ready  input  1  sink ready.
- busy  output  1  a frame is in progress.
- frame_seq  output  16  sequence number of the next frame to send.
- drop_count  output  16  requests dropped while busy; saturating.

Behaviour:
- Reset values: m_valid=0, m_data=0, m_last=0, busy=0, frame_seq=0, drop_count=0, req_q=0. The shadow registers, word index and state (IDLE) are also cleared.
- Edge detect: req_edge = snapshot_req & ~req_q, where req_q is registered snapshot_req. If snapshot_req is high at reset release, an edge fires on the first cycle after reset.
- States: IDLE and SEND. busy = (state == SEND).
- IDLE:
  - If req_edge and enable at clock edge N: capture all six counters into shadow registers at edge N, capture frame_seq into the header, set idx=0, go to SEND.
  - m_valid is high from cycle N+1 with word 0.
  - If req_edge and !enable: no action, not counted as dropped.
- SEND:
  - m_valid stays high.
  - m_data = word[idx] and m_last = (idx==7).
  - A handshake occurs when m_valid & m_ready; it advances idx.
  - m_data and m_last must hold stable while m_valid & !m_ready.
  - A handshake at idx=7 moves to IDLE, deasserts m_valid next cycle and increments frame_seq (wraps 16'hFFFF -> 0).
  - With m_ready held high, a frame takes exactly 8 cycles.
- Frame layout:
  - word0 = {HEADER_MAGIC, captured frame_seq}.
  - words 1..6 = icache_hit, icache_miss, icache_request, dcache_hit, dcache_miss, dcache_request.
  - word7 = XOR of words 0..6.
- Busy requests: any req_edge while state==SEND, including the cycle of the final handshake, is dropped.
  - drop_count increments by 1 and saturates at 16'hFFFF.
  - A dropped request is counted regardless of enable.
- enable deasserted during SEND: the current frame completes normally.
- Live counters changing after capture do not affect the frame in flight.
- A reset mid-frame aborts the frame: m_valid is low the cycle after reset, and no partial frame resumes.
- Arithmetic is unsigned modulo 2^32. No consistency check between miss, request and hit is performed; values are passed through unchanged.

Test Plan:
- Basic frame: counters ic_hit=10, ic_miss=2, ic_req=12, dc_hit=5, dc_miss=1, dc_req=6; one req pulse; m_ready=1. Required: 8 consecutive words 0xCA5E0000, 10, 2, 12, 5, 1, 6, 0xCA5E0006; m_last on word 8 only; frame_seq=1 afterwards.
- Backpressure: same frame with m_ready toggling 1,0,0,1,... Required: m_data/m_last hold stable during stalls; the word sequence is identical to the basic frame; no word is skipped or duplicated.
- Snapshot coherence: change all counters to 0xFFFFFFFF one cycle after capture. Required: the frame still carries the captured values; the next frame carries 0xFFFFFFFF values and header 0xCA5E0001.
- Drops: issue 3 req edges during one frame, one of them on the final-handshake cycle. Required: drop_count=3; exactly one frame is emitted. Also, req with enable=0 in IDLE gives no frame and drop_count unchanged.
- Wrap and saturation: preload by running 65536 frames. Required: header seq runs 0xFFFF then 0x0000; drop_count held at 0xFFFF after 65536+ drops.
- Reset mid-frame: assert rst after word 3 is accepted. Required: m_valid=0, frame_seq=0, drop_count=0 the next cycle; a new request then yields header 0xCA5E0000.

Source files
------------

// File: rtl/cache_profiler_reader.sv
// Cache profiler readout: on a snapshot request, latches all six counters
// in one cycle and streams them as an 8-word framed packet over valid/ready.
// Frame: {magic, seq}, six counters, then the XOR of the first seven words.
module cache_profiler_reader #(
  parameter logic [15:0] HEADER_MAGIC = 16'hCA5E
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        snapshot_req,
  input  logic [31:0] icache_hit_counter,
  input  logic [31:0] icache_miss_counter,
  input  logic [31:0] icache_request_counter,
  input  logic [31:0] dcache_hit_counter,
  input  logic [31:0] dcache_miss_counter,
  input  logic [31:0] dcache_request_counter,
  output logic        m_valid,
  output logic [31:0] m_data,
  output logic        m_last,
  input  logic        m_ready,
  output logic        busy,
  output logic [15:0] frame_seq,
  output logic [15:0] drop_count
);

  // state | meaning
  // IDLE  | waiting for a snapshot request, stream idle
  // SEND  | streaming the captured frame, one word per handshake
  typedef enum logic {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_t;

  state_t      state;
  logic        req_q;
  logic [2:0]  idx;
  logic [31:0] shadow [8];
  logic        req_edge;
  logic [31:0] header_w;
  logic [31:0] check_w;

  assign req_edge = snapshot_req & ~req_q;
  assign header_w = {HEADER_MAGIC, frame_seq};

  // Checksum computed from the live values so it lands in the same capture cycle.
  assign check_w = header_w ^ icache_hit_counter ^ icache_miss_counter ^
                   icache_request_counter ^ dcache_hit_counter ^
                   dcache_miss_counter ^ dcache_request_counter;

  // Request edge detect, capture, framing and drop accounting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      req_q      <= 1'b0;
      idx        <= 3'd0;
      m_valid    <= 1'b0;
      m_data     <= 32'd0;
      m_last     <= 1'b0;
      busy       <= 1'b0;
      frame_seq  <= 16'd0;
      drop_count <= 16'd0;
      for (int i = 0; i < 8; i++) shadow[i] <= 32'd0;
    end else begin
      req_q <= snapshot_req;
      case (state)
        ST_IDLE: begin
          if (req_edge && enable) begin
            shadow[0] <= header_w;
            shadow[1] <= icache_hit_counter;
            shadow[2] <= icache_miss_counter;
            shadow[3] <= icache_request_counter;
            shadow[4] <= dcache_hit_counter;
            shadow[5] <= dcache_miss_counter;
            shadow[6] <= dcache_request_counter;
            shadow[7] <= check_w;
            idx       <= 3'd0;
            state     <= ST_SEND;
            busy      <= 1'b1;
            m_valid   <= 1'b1;
            m_data    <= header_w;
            m_last    <= 1'b0;
          end
        end
        ST_SEND: begin
          // Any edge while a frame is in flight is lost, enable or not.
          if (req_edge && (drop_count != 16'hFFFF))
            drop_count <= drop_count + 16'd1;
          if (m_valid && m_ready) begin
            if (idx == 3'd7) begin
              state     <= ST_IDLE;
              busy      <= 1'b0;
              m_valid   <= 1'b0;
              m_data    <= 32'd0;
              m_last    <= 1'b0;
              frame_seq <= frame_seq + 16'd1;
            end else begin
              idx    <= idx + 3'd1;
              m_data <= shadow[idx + 3'd1];
              m_last <= (idx == 3'd6);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
